// File: rtl/decode_front_pkg.sv
// Shared opcode/funct constants, instruction classes and decode helper for decode_front.
// Branch-delay-slot behaviour is selected by the DECODE_DELAY_SLOT_EN macro in decode_front.
package decode_front_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_ADDU    = 6'h21;
    localparam logic [5:0] FN_SUBU    = 6'h23;

    localparam logic [31:0] NOP_INSTR     = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_BASE = 32'h0000_3000;

    typedef enum logic [3:0] {
        InsNop,
        InsAddu,
        InsSubu,
        InsOri,
        InsLui,
        InsLw,
        InsSw,
        InsBeq,
        InsJ,
        InsJal,
        InsJr
    } instr_e;

    // Anything outside the supported set collapses to InsNop.
    function automatic instr_e decode_instr(input logic [31:0] ir);
        instr_e kind;
        kind = InsNop;
        case (ir[31:26])
            OP_SPECIAL: begin
                case (ir[5:0])
                    FN_ADDU: kind = InsAddu;
                    FN_SUBU: kind = InsSubu;
                    FN_JR:   kind = InsJr;
                    default: kind = InsNop;
                endcase
            end
            OP_ORI:  kind = InsOri;
            OP_LUI:  kind = InsLui;
            OP_LW:   kind = InsLw;
            OP_SW:   kind = InsSw;
            OP_BEQ:  kind = InsBeq;
            OP_J:    kind = InsJ;
            OP_JAL:  kind = InsJal;
            default: kind = InsNop;
        endcase
        return kind;
    endfunction

endpackage

// File: rtl/decode_front_npc_unit.sv
// npc_unit: combinational branch/jump target and taken resolution for the D-stage instruction.
module decode_front_npc_unit
    import decode_front_pkg::*;
(
    input  logic [31:0] IR_D,
    input  logic [31:0] PC4_D,
    input  logic [31:0] rs_fwd_D,
    input  logic [31:0] rt_fwd_D,
    output logic [31:0] npc,
    output logic        taken
);

    instr_e      kind;
    logic [31:0] br_off;
    logic [31:0] br_target;
    logic [31:0] j_target;

    assign kind      = decode_instr(IR_D);
    assign br_off    = {{14{IR_D[15]}}, IR_D[15:0], 2'b00};
    assign br_target = PC4_D + br_off;
    assign j_target  = {PC4_D[31:28], IR_D[25:0], 2'b00};

    always_comb begin
        npc   = br_target;
        taken = 1'b0;
        unique case (kind)
            InsBeq: begin
                npc   = br_target;
                taken = (rs_fwd_D == rt_fwd_D);
            end
            InsJ, InsJal: begin
                npc   = j_target;
                taken = 1'b1;
            end
            InsJr: begin
                npc   = rs_fwd_D;
                taken = 1'b1;
            end
            default: begin
                npc   = br_target;
                taken = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/decode_front.sv
// MIPS decode front end: IF/ID register, branch/jump redirect and hazard stall.
// Define DECODE_DELAY_SLOT_EN for delay-slot semantics; otherwise a redirect squashes F.
module decode_front
    import decode_front_pkg::*;
#(
    parameter logic [31:0] RESET_PC4 = RESET_PC_BASE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PC4_F,
    input  logic [31:0] IR_F,
    input  logic [31:0] rs_fwd_D,
    input  logic [31:0] rt_fwd_D,
    input  logic [4:0]  wa_E,
    input  logic        ld_E,
    input  logic [4:0]  wa_M,
    input  logic        ld_M,
    output logic [31:0] IR_D,
    output logic [31:0] PC4_D,
    output logic [31:0] npc_D,
    output logic        pc_sel1_D,
    output logic        stall,
    output logic        flush_E
);

    instr_e     kind;
    logic [4:0] rs_d;
    logic [4:0] rt_d;
    logic       use_rs;
    logic       use_rt;
    logic       is_cmp;
    logic       hit_e;
    logic       hit_m;
    logic       taken;
    logic       squash;

    assign kind = decode_instr(IR_D);
    assign rs_d = IR_D[25:21];
    assign rt_d = IR_D[20:16];

    always_comb begin
        use_rs = 1'b0;
        use_rt = 1'b0;
        is_cmp = 1'b0;
        case (kind)
            InsAddu, InsSubu, InsSw: begin
                use_rs = 1'b1;
                use_rt = 1'b1;
            end
            InsOri, InsLw: use_rs = 1'b1;
            InsBeq: begin
                use_rs = 1'b1;
                use_rt = 1'b1;
                is_cmp = 1'b1;
            end
            InsJr: begin
                use_rs = 1'b1;
                is_cmp = 1'b1;
            end
            default: begin
                use_rs = 1'b0;
                use_rt = 1'b0;
                is_cmp = 1'b0;
            end
        endcase
    end

    // A zero destination means "no writer", so $0 sources can never match.
    assign hit_e = (wa_E != 5'd0) &&
                   ((use_rs && (rs_d == wa_E)) || (use_rt && (rt_d == wa_E)));
    assign hit_m = (wa_M != 5'd0) &&
                   ((use_rs && (rs_d == wa_M)) || (use_rt && (rt_d == wa_M)));

    // Branch compares in D see no E result at all, and only the M result of a load is late.
    assign stall = (ld_E && hit_e) || (is_cmp && hit_e) || (is_cmp && ld_M && hit_m);
    assign flush_E = stall;

    decode_front_npc_unit u_npc_unit (
        .IR_D     (IR_D),
        .PC4_D    (PC4_D),
        .rs_fwd_D (rs_fwd_D),
        .rt_fwd_D (rt_fwd_D),
        .npc      (npc_D),
        .taken    (taken)
    );

    assign pc_sel1_D = taken & ~stall;

`ifdef DECODE_DELAY_SLOT_EN
    assign squash = 1'b0;
`else
    assign squash = pc_sel1_D;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            IR_D  <= NOP_INSTR;
            PC4_D <= RESET_PC4;
        end else if (stall) begin
            IR_D  <= IR_D;
            PC4_D <= PC4_D;
        end else if (squash) begin
            IR_D  <= NOP_INSTR;
            PC4_D <= PC4_F;
        end else begin
            IR_D  <= IR_F;
            PC4_D <= PC4_F;
        end
    end

endmodule

// File: tb/tb_decode_front.sv
// Self-checking bench for decode_front: directed vector table, multi-cycle sequences,
// and randomized instructions against a mnemonic-level reference model.
module tb_decode_front;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] PC4_F, IR_F, rs_fwd_D, rt_fwd_D;
    logic [4:0]  wa_E, wa_M;
    logic        ld_E, ld_M;
    logic [31:0] IR_D, PC4_D, npc_D;
    logic        pc_sel1_D, stall, flush_E;

    int n_checks = 0;
    int n_fail   = 0;

    decode_front dut (
        .clk       (clk),
        .reset     (reset),
        .PC4_F     (PC4_F),
        .IR_F      (IR_F),
        .rs_fwd_D  (rs_fwd_D),
        .rt_fwd_D  (rt_fwd_D),
        .wa_E      (wa_E),
        .ld_E      (ld_E),
        .wa_M      (wa_M),
        .ld_M      (ld_M),
        .IR_D      (IR_D),
        .PC4_D     (PC4_D),
        .npc_D     (npc_D),
        .pc_sel1_D (pc_sel1_D),
        .stall     (stall),
        .flush_E   (flush_E)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] ir, pc4, rs, rt;
        logic [4:0]  wa_e;
        logic        ld_e;
        logic [4:0]  wa_m;
        logic        ld_m;
        logic        exp_stall, exp_sel, chk_npc;
        logic [31:0] exp_npc;
    } vec_t;

    typedef struct {
        logic        stall;
        logic        sel;
        logic        is_ctl;
        logic [31:0] npc;
    } ref_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input string nm, input logic [31:0] ir, input logic [31:0] pc4,
                       input logic [31:0] rs, input logic [31:0] rt, input logic [4:0] wa_e,
                       input logic ld_e, input logic [4:0] wa_m, input logic ld_m,
                       input logic st, input logic sel, input logic cn,
                       input logic [31:0] npc);
        vec_t v;
        v.name = nm; v.ir = ir; v.pc4 = pc4; v.rs = rs; v.rt = rt;
        v.wa_e = wa_e; v.ld_e = ld_e; v.wa_m = wa_m; v.ld_m = ld_m;
        v.exp_stall = st; v.exp_sel = sel; v.chk_npc = cn; v.exp_npc = npc;
        vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_hazards();
        wa_E = 5'd0; ld_E = 1'b0; wa_M = 5'd0; ld_M = 1'b0;
    endtask

    // Flush D with a nop first so a held or redirecting instruction cannot interfere.
    task automatic load(input logic [31:0] ir, input logic [31:0] pc4);
        clear_hazards();
        IR_F = 32'h0; PC4_F = 32'h0;
        tick();
        IR_F = ir; PC4_F = pc4;
        tick();
        IR_F = 32'h0; PC4_F = 32'h0;
    endtask

    function automatic ref_t model(input logic [31:0] ir, input logic [31:0] pc4,
                                   input logic [31:0] rs, input logic [31:0] rt,
                                   input logic [4:0] wa_e, input logic ld_e,
                                   input logic [4:0] wa_m, input logic ld_m);
        ref_t r;
        string m;
        int op, fn;
        int srcs[$];
        logic branchy;
        logic [31:0] off;
        op = int'(ir[31:26]);
        fn = int'(ir[5:0]);
        m = "nop";
        if (op == 0) begin
            if (fn == 'h21) m = "addu";
            else if (fn == 'h23) m = "subu";
            else if (fn == 'h08) m = "jr";
        end
        else if (op == 'h0D) m = "ori";
        else if (op == 'h0F) m = "lui";
        else if (op == 'h23) m = "lw";
        else if (op == 'h2B) m = "sw";
        else if (op == 'h04) m = "beq";
        else if (op == 'h02) m = "j";
        else if (op == 'h03) m = "jal";
        if (m == "addu" || m == "subu" || m == "ori" || m == "lw" || m == "sw" ||
            m == "beq" || m == "jr")
            srcs.push_back(int'(ir[25:21]));
        if (m == "addu" || m == "subu" || m == "sw" || m == "beq")
            srcs.push_back(int'(ir[20:16]));
        branchy = (m == "beq" || m == "jr");
        r.stall = 1'b0;
        foreach (srcs[i]) begin
            if (srcs[i] != 0) begin
                if (srcs[i] == int'(wa_e) && (ld_e || branchy)) r.stall = 1'b1;
                if (srcs[i] == int'(wa_m) && ld_m && branchy) r.stall = 1'b1;
            end
        end
        off = {{16{ir[15]}}, ir[15:0]};
        r.is_ctl = branchy || m == "j" || m == "jal";
        r.npc = 32'h0;
        if (m == "beq") r.npc = pc4 + off * 4;
        else if (m == "j" || m == "jal")
            r.npc = (pc4 & 32'hF000_0000) | ((ir & 32'h03FF_FFFF) << 2);
        else if (m == "jr") r.npc = rs;
        r.sel = ((m == "beq" && rs == rt) || m == "j" || m == "jal" || m == "jr") && !r.stall;
        return r;
    endfunction

    function automatic logic [31:0] build(input int kind, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd,
                                          input logic [15:0] imm);
        case (kind)
            0:  return {6'h00, rs, rt, rd, 5'h0, 6'h21};
            1:  return {6'h00, rs, rt, rd, 5'h0, 6'h23};
            2:  return {6'h0D, rs, rt, imm};
            3:  return {6'h0F, 5'h0, rt, imm};
            4:  return {6'h23, rs, rt, imm};
            5:  return {6'h2B, rs, rt, imm};
            6:  return {6'h04, rs, rt, imm};
            7:  return {6'h02, rs, rt, imm};
            8:  return {6'h03, rs, rt, imm};
            9:  return {6'h00, rs, 15'h0, 6'h08};
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] exp_ir;
        ref_t        r;
        logic [31:0] ir, pc4;

        reset = 1'b1;
        IR_F = 32'h0; PC4_F = 32'h0; rs_fwd_D = 32'h0; rt_fwd_D = 32'h0;
        clear_hazards();
        #1;
        check("reset_ir", IR_D, 32'h0);
        check("reset_pc4", PC4_D, 32'h0000_3000);
        check("reset_stall", {31'h0, stall}, 32'h0);
        check("reset_sel", {31'h0, pc_sel1_D}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        add("beq_taken",  32'h1022_0003, 32'h3004, 32'h5, 32'h5, 5'd0, 0, 5'd0, 0, 0, 1, 1, 32'h3010);
        add("beq_not",    32'h1022_0003, 32'h3004, 32'h5, 32'h6, 5'd0, 0, 5'd0, 0, 0, 0, 1, 32'h3010);
        add("lu_addu",    32'h0060_2021, 32'h3004, 32'h0, 32'h0, 5'd3, 1, 5'd0, 0, 1, 0, 0, 32'h0);
        add("lu_wa0",     32'h0060_2021, 32'h3004, 32'h0, 32'h0, 5'd0, 1, 5'd0, 0, 0, 0, 0, 32'h0);
        add("jal",        32'h0C00_0C10, 32'h3008, 32'h0, 32'h0, 5'd0, 0, 5'd0, 0, 0, 1, 1, 32'h3040);
        add("jr",         32'h03E0_0008, 32'h3010, 32'h300C, 32'h0, 5'd0, 0, 5'd0, 0, 0, 1, 1, 32'h300C);
        add("beq_alu_e",  32'h10E9_FFFF, 32'h3010, 32'h7, 32'h7, 5'd9, 0, 5'd0, 0, 1, 0, 1, 32'h300C);
        add("jr_ld_m",    32'h03E0_0008, 32'h3010, 32'h300C, 32'h0, 5'd0, 0, 5'd31, 1, 1, 0, 1, 32'h300C);
        add("jr_alu_m",   32'h03E0_0008, 32'h3010, 32'h300C, 32'h0, 5'd0, 0, 5'd31, 0, 0, 1, 1, 32'h300C);
        add("addu_ld_m",  32'h0060_2021, 32'h3004, 32'h0, 32'h0, 5'd0, 0, 5'd3, 1, 0, 0, 0, 32'h0);
        add("sw_lu_rt",   32'hACC5_0000, 32'h3004, 32'h0, 32'h0, 5'd5, 1, 5'd0, 0, 1, 0, 0, 32'h0);
        add("lui_noread", 32'h3C03_1234, 32'h3004, 32'h0, 32'h0, 5'd3, 1, 5'd0, 0, 0, 0, 0, 32'h0);
        add("ori_dest",   32'h3465_0010, 32'h3004, 32'h0, 32'h0, 5'd5, 1, 5'd0, 0, 0, 0, 0, 32'h0);
        add("ori_lu",     32'h3465_0010, 32'h3004, 32'h0, 32'h0, 5'd3, 1, 5'd0, 0, 1, 0, 0, 32'h0);
        add("subu_alu",   32'h00E9_1023, 32'h3004, 32'h0, 32'h0, 5'd9, 0, 5'd0, 0, 0, 0, 0, 32'h0);
        add("j_region",   32'h0800_0100, 32'h9000_0010, 32'h0, 32'h0, 5'd0, 0, 5'd0, 0, 0, 1, 1, 32'h9000_0400);
        add("junk_nop",   32'hFFFF_FFFF, 32'h3004, 32'h0, 32'h0, 5'd31, 1, 5'd31, 1, 0, 0, 0, 32'h0);
        add("jalr_nop",   32'h03E0_0009, 32'h3004, 32'h0, 32'h0, 5'd31, 1, 5'd0, 0, 0, 0, 0, 32'h0);
        add("beq_alu_m",  32'h1100_0002, 32'h3004, 32'h0, 32'h0, 5'd0, 0, 5'd8, 0, 0, 1, 1, 32'h300C);

        foreach (vecs[i]) begin
            load(vecs[i].ir, vecs[i].pc4);
            rs_fwd_D = vecs[i].rs; rt_fwd_D = vecs[i].rt;
            wa_E = vecs[i].wa_e; ld_E = vecs[i].ld_e;
            wa_M = vecs[i].wa_m; ld_M = vecs[i].ld_m;
            #1;
            check({vecs[i].name, "_ir"}, IR_D, vecs[i].ir);
            check({vecs[i].name, "_stall"}, {31'h0, stall}, {31'h0, vecs[i].exp_stall});
            check({vecs[i].name, "_flush"}, {31'h0, flush_E}, {31'h0, vecs[i].exp_stall});
            check({vecs[i].name, "_sel"}, {31'h0, pc_sel1_D}, {31'h0, vecs[i].exp_sel});
            if (vecs[i].chk_npc) check({vecs[i].name, "_npc"}, npc_D, vecs[i].exp_npc);
        end

        // Reset asserted mid-cycle while a stall is active.
        load(32'h1022_0003, 32'h3004);
        wa_E = 5'd1;
        #3;
        check("pre_reset_stall", {31'h0, stall}, 32'h1);
        reset = 1'b1;
        #1;
        check("midreset_ir", IR_D, 32'h0);
        check("midreset_pc4", PC4_D, 32'h3000);
        check("midreset_stall", {31'h0, stall}, 32'h0);
        check("midreset_flush", {31'h0, flush_E}, 32'h0);
        check("midreset_sel", {31'h0, pc_sel1_D}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        clear_hazards();

        // Taken beq: next-cycle IR_D depends on delay-slot mode.
        load(32'h1022_0003, 32'h3004);
        rs_fwd_D = 32'h5; rt_fwd_D = 32'h5;
        IR_F = 32'h0085_3021; PC4_F = 32'h3008;
        tick();
`ifdef DECODE_DELAY_SLOT_EN
        exp_ir = 32'h0085_3021;
`else
        exp_ir = 32'h0;
`endif
        check("redirect_ir", IR_D, exp_ir);
        check("redirect_pc4", PC4_D, 32'h3008);

        // Not-taken beq lets the fall-through instruction in.
        load(32'h1022_0003, 32'h3004);
        rs_fwd_D = 32'h5; rt_fwd_D = 32'h6;
        IR_F = 32'h0085_3021; PC4_F = 32'h3008;
        tick();
        check("fallthru_ir", IR_D, 32'h0085_3021);

        // Load-use: exactly one stall cycle with IR_D held.
        load(32'h0060_2021, 32'h3004);
        ld_E = 1'b1; wa_E = 5'd3;
        IR_F = 32'h3C03_1234; PC4_F = 32'h3008;
        #1;
        check("lu_seq_stall1", {31'h0, stall}, 32'h1);
        tick();
        check("lu_seq_hold_ir", IR_D, 32'h0060_2021);
        check("lu_seq_hold_pc4", PC4_D, 32'h3004);
        ld_E = 1'b0; wa_E = 5'd0; ld_M = 1'b1; wa_M = 5'd3;
        #1;
        check("lu_seq_stall2", {31'h0, stall}, 32'h0);
        tick();
        check("lu_seq_advance", IR_D, 32'h3C03_1234);

        // lw $8 feeding beq $8,$0: two stall cycles, then redirect.
        load(32'h1100_0002, 32'h3004);
        rs_fwd_D = 32'h0; rt_fwd_D = 32'h0;
        ld_E = 1'b1; wa_E = 5'd8;
        #1;
        check("ldbr_c1_stall", {31'h0, stall}, 32'h1);
        check("ldbr_c1_sel", {31'h0, pc_sel1_D}, 32'h0);
        tick();
        ld_E = 1'b0; wa_E = 5'd0; ld_M = 1'b1; wa_M = 5'd8;
        #1;
        check("ldbr_c2_ir", IR_D, 32'h1100_0002);
        check("ldbr_c2_stall", {31'h0, stall}, 32'h1);
        tick();
        ld_M = 1'b0; wa_M = 5'd0;
        #1;
        check("ldbr_c3_stall", {31'h0, stall}, 32'h0);
        check("ldbr_c3_sel", {31'h0, pc_sel1_D}, 32'h1);
        check("ldbr_c3_npc", npc_D, 32'h300C);

        // Randomized instructions against the reference model.
        for (int k = 0; k < 300; k++) begin
            ir  = build($urandom_range(0, 10), 5'($urandom_range(0, 7)),
                        5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom));
            pc4 = {$urandom, 2'b00} & 32'hFFFF_FFFC;
            load(ir, pc4);
            rs_fwd_D = 32'($urandom_range(0, 2)); rt_fwd_D = 32'($urandom_range(0, 2));
            if ($urandom_range(0, 3) == 0) rs_fwd_D = $urandom;
            wa_E = 5'($urandom_range(0, 7)); ld_E = 1'($urandom_range(0, 1));
            wa_M = 5'($urandom_range(0, 7)); ld_M = 1'($urandom_range(0, 1));
            r = model(ir, pc4, rs_fwd_D, rt_fwd_D, wa_E, ld_E, wa_M, ld_M);
            #1;
            check("rand_stall", {31'h0, stall}, {31'h0, r.stall});
            check("rand_flush", {31'h0, flush_E}, {31'h0, r.stall});
            check("rand_sel", {31'h0, pc_sel1_D}, {31'h0, r.sel});
            if (r.is_ctl) check("rand_npc", npc_D, r.npc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
